// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM states and the alignment rule.
package dmem_responder_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // An access is misaligned when any address bit below its natural size is set.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
        logic result;
        case (size)
            SIZE_H:  result = offset[0];
            SIZE_W:  result = |offset[1:0];
            SIZE_D:  result = |offset;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 64-bit doubleword: store data/mask placement
// and load lane selection with sign or zero extension.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [2:0]  offset,
    input  logic [63:0] wdata,
    input  logic [63:0] rdword,
    output logic [63:0] wdata_lane,
    output logic [63:0] wmask,
    output logic [63:0] rdata_ext
);

    logic [7:0]  byte_en_base;
    logic [7:0]  byte_en;
    logic [63:0] rd_shift;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which would infer a latch).
        byte_en_base = 8'h01;
        wmask        = '0;
        case (size)
            SIZE_B:  byte_en_base = 8'h01;
            SIZE_H:  byte_en_base = 8'h03;
            SIZE_W:  byte_en_base = 8'h0F;
            default: byte_en_base = 8'hFF;
        endcase
        byte_en    = byte_en_base << offset;
        for (int i = 0; i < 8; i++) begin
            wmask[8*i +: 8] = {8{byte_en[i]}};
        end
        wdata_lane = wdata << {offset, 3'b000};
    end

    always_comb begin
        rdata_ext = '0;
        rd_shift  = rdword >> {offset, 3'b000};
        case (size)
            SIZE_B:  rdata_ext = is_unsigned ? {56'd0, rd_shift[7:0]}
                                             : {{56{rd_shift[7]}}, rd_shift[7:0]};
            SIZE_H:  rdata_ext = is_unsigned ? {48'd0, rd_shift[15:0]}
                                             : {{48{rd_shift[15]}}, rd_shift[15:0]};
            SIZE_W:  rdata_ext = is_unsigned ? {32'd0, rd_shift[31:0]}
                                             : {{32{rd_shift[31]}}, rd_shift[31:0]};
            default: rdata_ext = rd_shift;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a doubleword array with a
// fixed, parameterised response latency and valid/ready handshakes.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [63:0] mem [DEPTH];

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;

    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic [1:0]  cur_size;
    logic        cur_unsigned;
    logic [63:0] cur_addr;
    logic [63:0] cur_wdata;
    logic        cur_err;
    logic [IDX_W-1:0] cur_idx;
    logic [63:0] rd_dword;
    logic [63:0] wdata_lane;
    logic [63:0] wmask;
    logic [63:0] rdata_ext;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state != RESP) && (state_next == RESP);

    // With LATENCY==1 the access happens on the acceptance edge itself, so the
    // live request is used; otherwise the latched copy is.
    always_comb begin
        if (state == IDLE) begin
            cur_we       = req_we;
            cur_size     = req_size;
            cur_unsigned = req_unsigned;
            cur_addr     = req_addr;
            cur_wdata    = req_wdata;
        end else begin
            cur_we       = lat_we;
            cur_size     = lat_size;
            cur_unsigned = lat_unsigned;
            cur_addr     = lat_addr;
            cur_wdata    = lat_wdata;
        end
    end

    assign cur_err  = misaligned(cur_size, cur_addr[2:0]) || (cur_addr[63:3] >= 61'(DEPTH));
    assign cur_idx  = cur_addr[3 +: IDX_W];
    assign rd_dword = mem[cur_idx];

    dmem_lane_align u_lane_align (
        .size        (cur_size),
        .is_unsigned (cur_unsigned),
        .offset      (cur_addr[2:0]),
        .wdata       (cur_wdata),
        .rdword      (rd_dword),
        .wdata_lane  (wdata_lane),
        .wmask       (wmask),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            lat_we       <= 1'b0;
            lat_size     <= SIZE_B;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            // NOTE: the storage is architecturally cleared on reset, so the
            // array is reset here (this forces flops rather than a RAM macro).
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                lat_we       <= req_we;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                cnt          <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_err || cur_we) ? 64'd0 : rdata_ext;
                if (cur_we && !cur_err) begin
                    mem[cur_idx] <= (rd_dword & ~wmask) | (wdata_lane & wmask);
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed vector table, stall/abort sequences, random
// accesses against a byte-array model, and a LATENCY=1 back-to-back run.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    logic        req_valid1, req_ready1, req_we1, req_unsigned1;
    logic [1:0]  req_size1;
    logic [63:0] req_addr1, req_wdata1;
    logic        rsp_valid1, rsp_err1;
    logic [63:0] rsp_rdata1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_mem [DEPTH*8];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
    } vec_t;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_size(req_size1), .req_unsigned(req_unsigned1), .req_addr(req_addr1),
        .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour from the access rules, on a flat byte array.
    task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                output logic [63:0] rdata, output logic err);
        int nbytes;
        logic [63:0] val;
        nbytes = 1 << size;
        err    = ((addr % 64'(nbytes)) != 0) || ((addr / 8) >= 64'(DEPTH));
        rdata  = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nbytes; i++) model_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                val = '0;
                for (int i = 0; i < nbytes; i++) val[8*i +: 8] = model_mem[int'(addr) + i];
                if (!uns && nbytes < 8 && val[8*nbytes-1]) val = val | (~64'd0 << (8*nbytes));
                rdata = val;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH*8; i++) model_mem[i] = 8'h00;
    endtask

    task automatic scramble_req();
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
    endtask

    // One full transaction on the LATENCY=2 instance; lat counts negedges
    // from the acceptance edge until rsp_valid is seen.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rdata, output logic err, output int lat);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        scramble_req();
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs [12];
        vec_t        ops  [4];
        logic [63:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat;

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; scramble_req();
        req_valid1 = 1'b0; req_we1 = 1'b0; req_size1 = SIZE_B; req_unsigned1 = 1'b0;
        req_addr1 = '0; req_wdata1 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // Directed vectors; memory state carries from one row to the next.
        vecs[0]  = '{1'b1, SIZE_D, 1'b0, 64'h10,  64'h1122334455667788, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, SIZE_D, 1'b0, 64'h10,  64'h0, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{1'b0, SIZE_B, 1'b0, 64'h17,  64'h0, 64'h0000000000000011, 1'b0};
        vecs[3]  = '{1'b1, SIZE_B, 1'b0, 64'h11,  64'hFFFFFFFFFFFFFF80, 64'h0, 1'b0};
        vecs[4]  = '{1'b0, SIZE_B, 1'b0, 64'h11,  64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0};
        vecs[5]  = '{1'b0, SIZE_B, 1'b1, 64'h11,  64'h0, 64'h0000000000000080, 1'b0};
        vecs[6]  = '{1'b0, SIZE_W, 1'b0, 64'h12,  64'h0, 64'h0, 1'b1};
        vecs[7]  = '{1'b1, SIZE_H, 1'b0, 64'h801, 64'h5A5A, 64'h0, 1'b1};
        vecs[8]  = '{1'b0, SIZE_D, 1'b0, 64'h10,  64'h0, 64'h1122334455668088, 1'b0};
        vecs[9]  = '{1'b1, SIZE_H, 1'b0, 64'h7FE, 64'h1234BEEF, 64'h0, 1'b0};
        vecs[10] = '{1'b0, SIZE_D, 1'b0, 64'h7F8, 64'h0, 64'hBEEF000000000000, 1'b0};
        vecs[11] = '{1'b0, SIZE_D, 1'b0, 64'h800, 64'h0, 64'h0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            xact(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            model_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                         exp_rd, exp_er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].err});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
        end

        // Stall with rsp_ready low while the request bus keeps changing.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_D; req_unsigned = 1'b0;
        req_addr = 64'h10; req_wdata = '0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        scramble_req();
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            scramble_req();
            lat++;
        end
        check("stall_latency", 64'(lat), 64'd2);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d_valid", c), {63'd0, rsp_valid}, 64'd1);
            check($sformatf("stall%0d_rdata", c), rsp_rdata, 64'h1122334455668088);
            check($sformatf("stall%0d_req_ready", c), {63'd0, req_ready}, 64'd0);
            @(negedge clk);
            scramble_req();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("stall_release_idle", {63'd0, req_ready}, 64'd1);
        check("stall_release_valid", {63'd0, rsp_valid}, 64'd0);

        // Reset while a store waits: nothing commits, everything clears.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_B; req_unsigned = 1'b0;
        req_addr = 64'h20; req_wdata = 64'hAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("abort_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("abort_rsp_rdata", rsp_rdata, 64'd0);
        check("abort_req_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        xact(1'b0, SIZE_B, 1'b1, 64'h20, 64'h0, rd, er, lat);
        check("abort_load20", rd, 64'd0);
        check("abort_load20_err", {63'd0, er}, 64'd0);
        xact(1'b0, SIZE_D, 1'b0, 64'h10, 64'h0, rd, er, lat);
        check("abort_storage_cleared", rd, 64'd0);

        // Random accesses against the byte-array model.
        for (int n = 0; n < 80; n++) begin
            logic        we, uns;
            logic [1:0]  size;
            logic [63:0] addr, wdata;
            logic [2:0]  off;
            we    = ($urandom_range(0, 2) != 0);
            size  = 2'($urandom);
            uns   = 1'($urandom);
            off   = 3'($urandom);
            if ($urandom_range(0, 3) != 0) off = off & ~3'((1 << size) - 1);
            addr  = (64'($urandom_range(0, DEPTH + 1)) << 3) | 64'(off);
            if (n < 40) addr = addr & 64'h3F;  // dense first half so loads hit stored data
            wdata = {$urandom, $urandom};
            xact(we, size, uns, addr, wdata, rd, er, lat);
            model_access(we, size, uns, addr, wdata, exp_rd, exp_er);
            check($sformatf("rand%0d_rdata", n), rd, exp_rd);
            check($sformatf("rand%0d_err", n), {63'd0, er}, {63'd0, exp_er});
            check($sformatf("rand%0d_latency", n), 64'(lat), 64'd2);
        end

        // LATENCY=1, rsp_ready tied high, request held valid every cycle.
        ops[0] = '{1'b1, SIZE_D, 1'b0, 64'h8, 64'hCAFEF00D12345678, 64'h0, 1'b0};
        ops[1] = '{1'b0, SIZE_D, 1'b0, 64'h8, 64'h0, 64'hCAFEF00D12345678, 1'b0};
        ops[2] = '{1'b0, SIZE_H, 1'b1, 64'hA, 64'h0, 64'h0000000000001234, 1'b0};
        ops[3] = '{1'b0, SIZE_H, 1'b0, 64'hE, 64'h0, 64'hFFFFFFFFFFFFCAFE, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("l1_cyc%0d_req_ready", k), {63'd0, req_ready1}, 64'((k % 2) == 0));
            check($sformatf("l1_cyc%0d_rsp_valid", k), {63'd0, rsp_valid1}, 64'((k % 2) == 1));
            if ((k % 2) == 0) begin
                req_valid1 = 1'b1;
                req_we1 = ops[k/2].we; req_size1 = ops[k/2].size; req_unsigned1 = ops[k/2].uns;
                req_addr1 = ops[k/2].addr; req_wdata1 = ops[k/2].wdata;
            end else begin
                check($sformatf("l1_op%0d_rdata", k/2), rsp_rdata1, ops[k/2].rdata);
                check($sformatf("l1_op%0d_err", k/2), {63'd0, rsp_err1}, {63'd0, ops[k/2].err});
            end
            @(negedge clk);
        end
        req_valid1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the number of 64-bit doublewords of storage.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request acceptance to response valid; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the core presents a load/store request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits: access size; 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 The block SHALL have port req_unsigned, input, 1 bit: for loads, 1 = zero-extend and 0 = sign-extend.
REQ-010 The block SHALL have port req_addr, input, 64 bits: byte address.
REQ-011 The block SHALL have port req_wdata, input, 64 bits: store data; only the low 8·2^size bits are used.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the core consumes the response.
REQ-014 The block SHALL have port rsp_rdata, output, 64 bits: the extended load data; it is 0 for stores and for errors.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: the access was misaligned or out of range.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on an edge where req_valid && req_ready.
REQ-018 On acceptance, the block SHALL latch we, size, unsigned, addr and wdata, load the latency counter with LATENCY-1, and enter WAIT; if LATENCY==1 it SHALL enter RESP directly.
REQ-019 In WAIT the counter SHALL decrement every cycle, and the FSM SHALL enter RESP on the edge where the counter is 0.
REQ-020 rsp_valid SHALL assert exactly LATENCY cycles after the acceptance edge and remain asserted, with stable rdata and err, until rsp_valid && rsp_ready.
REQ-021 On the response handshake the FSM SHALL return to IDLE; a new request is accepted no earlier than the following edge (no same-cycle overlap).
REQ-022 Error SHALL be defined as: misaligned (addr bits [size-1:0] nonzero for size>0) OR (addr >> 3) >= DEPTH.
REQ-023 Stores SHALL be little-endian byte-lane writes, committed on the edge entering RESP, and only when there is no error; other bytes SHALL be unchanged.
REQ-024 Loads SHALL read the addressed doubleword on the edge entering RESP, select lanes by addr[2:0] and size, and extend per req_unsigned.
REQ-025 An erroring access SHALL NOT modify storage and SHALL return rsp_rdata = 0 with rsp_err = 1.
REQ-026 req_* inputs SHALL be ignored outside the acceptance edge; changes during WAIT or RESP SHALL have no effect.
REQ-027 A held rsp_valid with rsp_ready low SHALL stall indefinitely without losing data.

Reset
REQ-028 On rst the FSM SHALL go to IDLE and the counter SHALL be cleared.
REQ-029 On rst, rsp_valid, rsp_err and rsp_rdata SHALL be 0, and all storage SHALL be cleared to 0.
REQ-030 rst asserted in WAIT SHALL abort the access; the pending store SHALL NOT commit.
REQ-031 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-032 A shared package SHALL hold the size encodings (SIZE_B/H/W/D) and the FSM state enum.
REQ-033 One sub-module, dmem_lane_align, SHALL hold the combinational store byte-enable/shift and the load select/extend logic.

Verification
REQ-034 Verification SHALL cover: store double 0x1122334455667788 @0x10, then load double @0x10 -> rdata 0x1122334455667788, err 0, rsp_valid exactly 2 cycles after each acceptance.
REQ-035 Verification SHALL cover: after REQ-034, load byte signed @0x17 -> 0x0000000000000011; store byte 0x80 @0x11, then load byte signed @0x11 -> 0xFFFFFFFFFFFFFF80 and load byte unsigned @0x11 -> 0x80.
REQ-036 Verification SHALL cover: load word @0x12 -> err 1, rdata 0; store half @0x801 (DEPTH 256) -> err 1 and memory unchanged.
REQ-037 Verification SHALL cover: hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable and req_ready 0 throughout; rsp_ready=1 -> IDLE on the next edge.
REQ-038 Verification SHALL cover: accept store 0xAA @0x20, then assert rst in WAIT -> all outputs 0 and a subsequent load @0x20 returns 0.
REQ-039 Verification SHALL cover: LATENCY=1 back-to-back requests with rsp_ready tied high -> one response every 2 cycles, and req_ready toggles 1/0.
